// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake/bus signal around mem_port_arbiter: the CPU
// instruction-fetch port, the CPU data port and the unified memory port.
// The slave modport is the arbiter's view (it serves the CPU requesters and
// drives the memory port); the master modport is the surrounding system.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic [DATA_W-1:0]     inst_rdata;
  logic                  inst_ready;

  // Data requester
  logic                  data_req;
  logic                  data_wr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic [DATA_W-1:0]     data_rdata;
  logic                  data_ready;

  // Shared memory port
  logic                  mem_req;
  logic                  mem_wr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport slave (
    input  inst_req, inst_addr,
    output inst_rdata, inst_ready,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_rdata, data_ready,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output busy
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_rdata, inst_ready,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_rdata, data_ready,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and data
// requesters. Data wins conflicts, except that after STARVE_MAX consecutive
// lost conflicts the fetch side is granted. Each grant is latched into the
// mem_* registers, held until mem_ack, and completed with a one-cycle ready.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int               STRB_W     = DATA_W / 8;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t              state;
  logic [CNT_W-1:0]    starve_cnt;

  logic                mem_req_q;
  logic                mem_wr_q;
  logic [STRB_W-1:0]   mem_wstrb_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   inst_rdata_q;
  logic                inst_ready_q;
  logic [DATA_W-1:0]   data_rdata_q;
  logic                data_ready_q;

  logic                starved;
  logic                grant_inst;
  logic                grant_data;

  // Arbitration decision for the current cycle (only acted on in IDLE)
  always_comb begin
    starved    = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM);
    grant_inst = bus.inst_req && (!bus.data_req || starved);
    grant_data = bus.data_req && !grant_inst;
  end

  // Arbiter FSM with registered memory-port and completion outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      inst_ready_q <= 1'b0;
      data_rdata_q <= '0;
      data_ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_inst) begin
            starve_cnt  <= '0;
            mem_req_q   <= 1'b1;
            mem_wr_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= bus.inst_addr;
            mem_wdata_q <= '0;
            state       <= BUSY_I;
          end else if (grant_data) begin
            // Count only conflicts the fetch side actually lost
            if (bus.inst_req && (starve_cnt != STARVE_LIM))
              starve_cnt <= starve_cnt + CNT_W'(1);
            mem_req_q   <= 1'b1;
            mem_wr_q    <= bus.data_wr;
            mem_wstrb_q <= bus.data_wr ? bus.data_wstrb : '0;
            mem_addr_q  <= bus.data_addr;
            mem_wdata_q <= bus.data_wdata;
            state       <= BUSY_D;
          end
        end
        BUSY_I: begin
          if (bus.mem_ack) begin
            mem_req_q    <= 1'b0;
            inst_rdata_q <= bus.mem_rdata;
            inst_ready_q <= 1'b1;
            state        <= RESP_I;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack) begin
            mem_req_q    <= 1'b0;
            data_rdata_q <= mem_wr_q ? '0 : bus.mem_rdata;
            data_ready_q <= 1'b1;
            state        <= RESP_D;
          end
        end
        RESP_I: begin
          inst_ready_q <= 1'b0;
          state        <= IDLE;
        end
        RESP_D: begin
          data_ready_q <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.inst_ready = inst_ready_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.data_ready = data_ready_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances cover STARVE_MAX of
// 4, 2 and 0. A latency-programmable memory model answers each instance, and
// a scoreboard per instance holds the expected order/data of ready pulses.
module tb_mem_port_arbiter;
  // Memory returns addr ^ RD_KEY, so 0xBFC00000 reads back 0x24080001
  localparam logic [31:0] RD_KEY = 32'h9BC8_0001;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t exp_c[$];

  int cnt[3];
  int lat[3];
  bit acked[3];
  bit stray[3];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ia ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ic ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .CNT_W(3))
    dut_a (.clk(clk), .rst(rst_n), .bus(ia));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2), .CNT_W(3))
    dut_b (.clk(clk), .rst(rst_n), .bus(ib));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(0), .CNT_W(3))
    dut_c (.clk(clk), .rst(rst_n), .bus(ic));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input int w, input logic is_data, input logic [31:0] rd);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rd;
    case (w)
      0:       exp_a.push_back(e);
      1:       exp_b.push_back(e);
      default: exp_c.push_back(e);
    endcase
  endtask

  // Memory model: ack after lat[w] cycles of mem_req, plus forced stray acks
  task automatic mem_step(input int w, input logic req, input logic [31:0] addr,
                          output logic ack, output logic [31:0] rd);
    ack = 1'b0;
    rd  = 32'h0BAD_0BAD;
    if (req && !acked[w]) begin
      cnt[w]++;
      if (cnt[w] >= lat[w]) begin
        ack      = 1'b1;
        rd       = addr ^ RD_KEY;
        cnt[w]   = 0;
        acked[w] = 1'b1;
      end
    end else begin
      cnt[w]   = 0;
      acked[w] = 1'b0;
    end
    if (stray[w]) ack = 1'b1;
  endtask

  // Scoreboard: every ready pulse must match the head of the expected queue
  task automatic sb_check(input int w, input logic ir, input logic dr,
                          input logic [31:0] ird, input logic [31:0] drd);
    exp_t e;
    int   sz;
    if (ir || dr) begin
      check($sformatf("both_ready_%0d", w), 32'(ir & dr), 32'd0);
      case (w)
        0:       sz = exp_a.size();
        1:       sz = exp_b.size();
        default: sz = exp_c.size();
      endcase
      check($sformatf("sb_has_entry_%0d", w), 32'(sz != 0), 32'd1);
      if (sz != 0) begin
        case (w)
          0:       e = exp_a.pop_front();
          1:       e = exp_b.pop_front();
          default: e = exp_c.pop_front();
        endcase
        check($sformatf("sb_port_%0d", w), 32'(dr), 32'(e.is_data));
        check($sformatf("sb_rdata_%0d", w), dr ? drd : ird, e.rdata);
      end
    end
  endtask

  always @(negedge clk) mem_step(0, ia.mem_req, ia.mem_addr, ia.mem_ack, ia.mem_rdata);
  always @(negedge clk) mem_step(1, ib.mem_req, ib.mem_addr, ib.mem_ack, ib.mem_rdata);
  always @(negedge clk) mem_step(2, ic.mem_req, ic.mem_addr, ic.mem_ack, ic.mem_rdata);

  always @(negedge clk) sb_check(0, ia.inst_ready, ia.data_ready, ia.inst_rdata, ia.data_rdata);
  always @(negedge clk) sb_check(1, ib.inst_ready, ib.data_ready, ib.inst_rdata, ib.data_rdata);
  always @(negedge clk) sb_check(2, ic.inst_ready, ic.data_ready, ic.inst_rdata, ic.data_rdata);

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_cyc;
    int i_cyc;
    int dcount;
    int pulses;
    bit done;

    rst_n = 1'b0;
    lat   = '{1, 1, 1};
    stray = '{0, 0, 0};
    ia.inst_req = 0; ia.inst_addr = '0; ia.data_req = 0; ia.data_wr = 0;
    ia.data_wstrb = '0; ia.data_addr = '0; ia.data_wdata = '0;
    ib.inst_req = 0; ib.inst_addr = '0; ib.data_req = 0; ib.data_wr = 0;
    ib.data_wstrb = '0; ib.data_addr = '0; ib.data_wdata = '0;
    ic.inst_req = 0; ic.inst_addr = '0; ic.data_req = 0; ic.data_wr = 0;
    ic.data_wstrb = '0; ic.data_addr = '0; ic.data_wdata = '0;

    // Reset state
    step(); step();
    check("rst_mem_req", 32'(ia.mem_req), 32'd0);
    check("rst_busy", 32'(ia.busy), 32'd0);
    check("rst_inst_ready", 32'(ia.inst_ready), 32'd0);
    check("rst_data_ready", 32'(ia.data_ready), 32'd0);
    check("rst_inst_rdata", ia.inst_rdata, 32'd0);
    check("rst_mem_addr", ia.mem_addr, 32'd0);
    check("rst_busy_c", 32'(ic.busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Inst-only read with single-cycle memory
    ia.inst_req  = 1'b1;
    ia.inst_addr = 32'hBFC0_0000;
    push_exp(0, 1'b0, 32'h2408_0001);
    step();
    check("t1_mem_req", 32'(ia.mem_req), 32'd1);
    check("t1_mem_addr", ia.mem_addr, 32'hBFC0_0000);
    check("t1_mem_wr", 32'(ia.mem_wr), 32'd0);
    check("t1_mem_wstrb", 32'(ia.mem_wstrb), 32'd0);
    check("t1_busy", 32'(ia.busy), 32'd1);
    step();
    check("t1_inst_ready", 32'(ia.inst_ready), 32'd1);
    check("t1_inst_rdata", ia.inst_rdata, 32'h2408_0001);
    ia.inst_req = 1'b0;
    step();
    check("t1_busy_low", 32'(ia.busy), 32'd0);
    check("t1_ready_cleared", 32'(ia.inst_ready), 32'd0);
    step();

    // Conflict, latency 3. Data: mem_req t+1, ack t+3, ready t+4, RESP t+4,
    // IDLE t+5; inst: mem_req t+6, ack t+8, ready t+9.
    lat[0] = 3;
    ia.inst_req  = 1'b1;
    ia.inst_addr = 32'h0040_0000;
    ia.data_req  = 1'b1;
    ia.data_wr   = 1'b0;
    ia.data_addr = 32'h8000_1000;
    push_exp(0, 1'b1, 32'h8000_1000 ^ RD_KEY);
    push_exp(0, 1'b0, 32'h0040_0000 ^ RD_KEY);
    d_cyc = -1;
    i_cyc = -1;
    for (int c = 1; c <= 30 && i_cyc < 0; c++) begin
      step();
      if (c == 1) check("t2_starve_after_loss", 32'(dut_a.starve_cnt), 32'd1);
      if (ia.data_ready) begin d_cyc = c; ia.data_req = 1'b0; end
      if (ia.inst_ready) begin i_cyc = c; ia.inst_req = 1'b0; end
    end
    check("t2_data_ready_cycle", d_cyc, 32'd4);
    check("t2_inst_ready_cycle", i_cyc, 32'd9);
    step();
    check("t2_starve_end", 32'(dut_a.starve_cnt), 32'd0);
    step();

    // Data write, latency 5, requester inputs scrambled while busy
    lat[0] = 5;
    ia.data_req   = 1'b1;
    ia.data_wr    = 1'b1;
    ia.data_wstrb = 4'b0011;
    ia.data_addr  = 32'h8000_2000;
    ia.data_wdata = 32'hDEAD_BEEF;
    push_exp(0, 1'b1, 32'h0);
    pulses = 0;
    d_cyc  = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (ia.data_req) begin
        ia.data_wr    = 1'b0;
        ia.data_wstrb = 4'($urandom);
        ia.data_addr  = $urandom;
        ia.data_wdata = $urandom;
      end
      if (ia.mem_req) begin
        check("t4_mem_addr", ia.mem_addr, 32'h8000_2000);
        check("t4_mem_wdata", ia.mem_wdata, 32'hDEAD_BEEF);
        check("t4_mem_wstrb", 32'(ia.mem_wstrb), 32'h3);
        check("t4_mem_wr", 32'(ia.mem_wr), 32'd1);
      end
      if (ia.data_ready) begin
        pulses++;
        d_cyc = c;
        ia.data_req = 1'b0;
        check("t4_data_rdata", ia.data_rdata, 32'd0);
      end
    end
    check("t4_ready_pulses", pulses, 32'd1);
    check("t4_ready_cycle", d_cyc, 32'd6);

    // Reset in the middle of BUSY_I
    lat[0] = 6;
    ia.inst_req  = 1'b1;
    ia.inst_addr = 32'h0000_1000;
    step(); step();
    check("t5_pre_mem_req", 32'(ia.mem_req), 32'd1);
    check("t5_pre_busy", 32'(ia.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_mem_req", 32'(ia.mem_req), 32'd0);
    check("t5_rst_busy", 32'(ia.busy), 32'd0);
    check("t5_rst_inst_ready", 32'(ia.inst_ready), 32'd0);
    check("t5_rst_data_ready", 32'(ia.data_ready), 32'd0);
    ia.inst_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    stray[0] = 1'b1;
    step();
    stray[0] = 1'b0;
    step(); step();
    check("t5_stray_busy", 32'(ia.busy), 32'd0);
    check("t5_stray_mem_req", 32'(ia.mem_req), 32'd0);
    lat[0] = 1;
    ia.inst_req  = 1'b1;
    ia.inst_addr = 32'h0000_2000;
    push_exp(0, 1'b0, 32'h0000_2000 ^ RD_KEY);
    i_cyc = -1;
    for (int c = 1; c <= 10 && i_cyc < 0; c++) begin
      step();
      if (ia.inst_ready) begin i_cyc = c; ia.inst_req = 1'b0; end
    end
    check("t5_post_rst_ready_cycle", i_cyc, 32'd2);

    // STARVE_MAX=2, data held continuously: grant order D, D, I, D
    ib.inst_req  = 1'b1;
    ib.inst_addr = 32'h0000_3000;
    ib.data_req  = 1'b1;
    ib.data_wr   = 1'b0;
    ib.data_addr = 32'h0000_4000;
    push_exp(1, 1'b1, 32'h0000_4000 ^ RD_KEY);
    push_exp(1, 1'b1, 32'h0000_4000 ^ RD_KEY);
    push_exp(1, 1'b0, 32'h0000_3000 ^ RD_KEY);
    push_exp(1, 1'b1, 32'h0000_4000 ^ RD_KEY);
    dcount = 0;
    done   = 1'b0;
    for (int c = 1; c <= 60 && !(done && dcount >= 3); c++) begin
      step();
      if (ib.inst_ready) begin
        done = 1'b1;
        ib.inst_req = 1'b0;
        check("t3_inst_after_two_data", dcount, 32'd2);
      end
      if (ib.data_ready) begin
        dcount++;
        if (dcount == 3) ib.data_req = 1'b0;
      end
    end
    check("t3_inst_done", 32'(done), 32'd1);
    check("t3_data_count", dcount, 32'd3);
    step();
    check("t3_starve_end", 32'(dut_b.starve_cnt), 32'd0);

    // Stray ack with no request, then STARVE_MAX=0 under conflict
    stray[2] = 1'b1;
    step();
    stray[2] = 1'b0;
    step(); step();
    check("t6_stray_busy", 32'(ic.busy), 32'd0);
    check("t6_stray_inst_ready", 32'(ic.inst_ready), 32'd0);
    check("t6_stray_data_ready", 32'(ic.data_ready), 32'd0);
    lat[2] = 2;
    ic.inst_req  = 1'b1;
    ic.inst_addr = 32'h0000_5000;
    ic.data_req  = 1'b1;
    ic.data_wr   = 1'b0;
    ic.data_addr = 32'h0000_6000;
    for (int k = 0; k < 3; k++) push_exp(2, 1'b1, 32'h0000_6000 ^ RD_KEY);
    push_exp(2, 1'b0, 32'h0000_5000 ^ RD_KEY);
    dcount = 0;
    done   = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      step();
      if (ic.inst_ready) begin
        done = 1'b1;
        ic.inst_req = 1'b0;
        check("t6_inst_after_data_drop", dcount, 32'd3);
      end
      if (ic.data_ready) begin
        dcount++;
        if (dcount == 3) ic.data_req = 1'b0;
      end
    end
    check("t6_inst_done", 32'(done), 32'd1);

    step(); step();
    check("sb_drained_a", exp_a.size(), 32'd0);
    check("sb_drained_b", exp_b.size(), 32'd0);
    check("sb_drained_c", exp_c.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
